// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequencer for multi-cycle mult/div units with HI/LO write-back
module muldiv_seq #(
   parameter int TIMEOUT = 40,
   parameter int CNT_W   = 6
) (
   input  logic clock,
   input  logic reset,
   input  logic StartMult,
   input  logic StartDiv,
   input  logic MultDone,
   input  logic DivDone,
   input  logic Div0,
   output logic MultCtrl,
   output logic DivCtrl,
   output logic HICtrl,
   output logic LOCtrl,
   output logic WriteHI,
   output logic WriteLO,
   output logic Busy,
   output logic OpDone,
   output logic DivZeroExc,
   output logic TimeoutExc,
   output logic ReqErr
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      MULT_RUN = 3'd1,
      DIV_RUN  = 3'd2,
      WB       = 3'd3,
      EXC      = 3'd4
   } state_t;

   // Last RUN cycle before the unit is declared hung; the counter saturates at all-ones.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mult_ctrl_q, mult_ctrl_d;
   logic             div_ctrl_q, div_ctrl_d;
   logic             hi_ctrl_q, hi_ctrl_d;
   logic             lo_ctrl_q, lo_ctrl_d;
   logic             req_err_q, req_err_d;
   logic             div_zero_exc_q, div_zero_exc_d;
   logic             timeout_exc_q, timeout_exc_d;
   logic             any_start;
   logic             cnt_expired;

   assign any_start   = StartMult | StartDiv;
   assign cnt_expired = (cnt_q == CNT_LAST);

   // Next-state and registered-output computation; pulses default low, mux selects hold.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      mult_ctrl_d    = 1'b0;
      div_ctrl_d     = 1'b0;
      hi_ctrl_d      = hi_ctrl_q;
      lo_ctrl_d      = lo_ctrl_q;
      req_err_d      = 1'b0;
      div_zero_exc_d = 1'b0;
      timeout_exc_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (StartMult) begin
               state_d     = MULT_RUN;
               cnt_d       = '0;
               mult_ctrl_d = 1'b1;
               req_err_d   = StartDiv;   // a simultaneous div request is dropped
            end else if (StartDiv) begin
               state_d    = DIV_RUN;
               cnt_d      = '0;
               div_ctrl_d = 1'b1;
            end
         end
         MULT_RUN: begin
            req_err_d = any_start;
            cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            if (MultDone) begin
               state_d   = WB;
               hi_ctrl_d = 1'b1;
               lo_ctrl_d = 1'b1;
            end else if (cnt_expired) begin
               state_d       = EXC;
               timeout_exc_d = 1'b1;
            end
         end
         DIV_RUN: begin
            req_err_d = any_start;
            cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            if (Div0) begin
               state_d        = EXC;
               div_zero_exc_d = 1'b1;
            end else if (DivDone) begin
               state_d   = WB;
               hi_ctrl_d = 1'b0;
               lo_ctrl_d = 1'b0;
            end else if (cnt_expired) begin
               state_d       = EXC;
               timeout_exc_d = 1'b1;
            end
         end
         WB: begin
            req_err_d = any_start;
            state_d   = IDLE;
         end
         EXC: begin
            req_err_d = any_start;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset clears everything without waiting for a clock.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         mult_ctrl_q    <= 1'b0;
         div_ctrl_q     <= 1'b0;
         hi_ctrl_q      <= 1'b0;
         lo_ctrl_q      <= 1'b0;
         req_err_q      <= 1'b0;
         div_zero_exc_q <= 1'b0;
         timeout_exc_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         mult_ctrl_q    <= mult_ctrl_d;
         div_ctrl_q     <= div_ctrl_d;
         hi_ctrl_q      <= hi_ctrl_d;
         lo_ctrl_q      <= lo_ctrl_d;
         req_err_q      <= req_err_d;
         div_zero_exc_q <= div_zero_exc_d;
         timeout_exc_q  <= timeout_exc_d;
      end
   end

   assign MultCtrl   = mult_ctrl_q;
   assign DivCtrl    = div_ctrl_q;
   assign HICtrl     = hi_ctrl_q;
   assign LOCtrl     = lo_ctrl_q;
   assign WriteHI    = (state_q == WB);
   assign WriteLO    = (state_q == WB);
   assign OpDone     = (state_q == WB);
   assign Busy       = (state_q != IDLE);
   assign DivZeroExc = div_zero_exc_q;
   assign TimeoutExc = timeout_exc_q;
   assign ReqErr     = req_err_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed self-checking bench for muldiv_seq
`timescale 1ns/100ps
module tb_muldiv_seq;

   logic clock;
   logic reset;
   logic StartMult, StartDiv, MultDone, DivDone, Div0;
   logic MultCtrl, DivCtrl, HICtrl, LOCtrl, WriteHI, WriteLO;
   logic Busy, OpDone, DivZeroExc, TimeoutExc, ReqErr;

   int compared   = 0;
   int mismatched = 0;

   // Output vector bit order:
   // [10]MultCtrl [9]DivCtrl [8]HICtrl [7]LOCtrl [6]WriteHI [5]WriteLO
   // [4]Busy [3]OpDone [2]DivZeroExc [1]TimeoutExc [0]ReqErr
   logic [10:0] outs;
   assign outs = {MultCtrl, DivCtrl, HICtrl, LOCtrl, WriteHI, WriteLO,
                  Busy, OpDone, DivZeroExc, TimeoutExc, ReqErr};

   muldiv_seq #(.TIMEOUT(40), .CNT_W(6)) dut (
      .clock      (clock),
      .reset      (reset),
      .StartMult  (StartMult),
      .StartDiv   (StartDiv),
      .MultDone   (MultDone),
      .DivDone    (DivDone),
      .Div0       (Div0),
      .MultCtrl   (MultCtrl),
      .DivCtrl    (DivCtrl),
      .HICtrl     (HICtrl),
      .LOCtrl     (LOCtrl),
      .WriteHI    (WriteHI),
      .WriteLO    (WriteLO),
      .Busy       (Busy),
      .OpDone     (OpDone),
      .DivZeroExc (DivZeroExc),
      .TimeoutExc (TimeoutExc),
      .ReqErr     (ReqErr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [10:0] exp);
      compared++;
      assert (outs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%b expected=%b", tag, outs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      StartMult = 1'b0; StartDiv = 1'b0;
      MultDone = 1'b0; DivDone = 1'b0; Div0 = 1'b0;
      #2;
      chk("reset_async", 11'b0_0_0_0_0_0_0_0_0_0_0);
      tick();
      reset = 1'b0;
      tick();
      chk("idle_after_reset", 11'b0_0_0_0_0_0_0_0_0_0_0);

      // Mult: start at T, done held in cycle T+5
      StartMult = 1'b1;
      tick();
      StartMult = 1'b0;
      chk("mult_t1_multctrl", 11'b1_0_0_0_0_0_1_0_0_0_0);
      tick();
      chk("mult_t2", 11'b0_0_0_0_0_0_1_0_0_0_0);
      tick();
      tick();
      chk("mult_t4", 11'b0_0_0_0_0_0_1_0_0_0_0);
      tick();
      MultDone = 1'b1;
      chk("mult_t5", 11'b0_0_0_0_0_0_1_0_0_0_0);
      tick();
      MultDone = 1'b0;
      chk("mult_t6_wb", 11'b0_0_1_1_1_1_1_1_0_0_0);
      tick();
      chk("mult_t7_idle", 11'b0_0_1_1_0_0_0_0_0_0_0);

      // Back-to-back div in the IDLE cycle after WB, done in its first RUN cycle
      StartDiv = 1'b1;
      tick();
      StartDiv = 1'b0;
      DivDone = 1'b1;
      chk("b2b_divctrl", 11'b0_1_1_1_0_0_1_0_0_0_0);
      tick();
      DivDone = 1'b0;
      chk("b2b_div_wb", 11'b0_0_0_0_1_1_1_1_0_0_0);
      tick();
      chk("b2b_idle", 11'b0_0_0_0_0_0_0_0_0_0_0);

      // Div0 and DivDone together in the third RUN cycle
      StartDiv = 1'b1;
      tick();
      StartDiv = 1'b0;
      chk("div0_run1", 11'b0_1_0_0_0_0_1_0_0_0_0);
      tick();
      tick();
      Div0 = 1'b1; DivDone = 1'b1;
      tick();
      Div0 = 1'b0; DivDone = 1'b0;
      chk("div0_exc", 11'b0_0_0_0_0_0_1_0_1_0_0);
      tick();
      chk("div0_idle", 11'b0_0_0_0_0_0_0_0_0_0_0);

      // Timeout after 40 DIV_RUN cycles with no done
      StartDiv = 1'b1;
      tick();
      StartDiv = 1'b0;
      for (int i = 2; i <= 40; i++) tick();
      chk("to_run40", 11'b0_0_0_0_0_0_1_0_0_0_0);
      tick();
      chk("to_exc", 11'b0_0_0_0_0_0_1_0_0_1_0);
      tick();
      chk("to_idle", 11'b0_0_0_0_0_0_0_0_0_0_0);

      // DivDone in RUN cycle 40 wins over the timeout
      StartDiv = 1'b1;
      tick();
      StartDiv = 1'b0;
      for (int i = 2; i <= 40; i++) tick();
      DivDone = 1'b1;
      tick();
      DivDone = 1'b0;
      chk("to_done_wb", 11'b0_0_0_0_1_1_1_1_0_0_0);
      tick();
      chk("to_done_idle", 11'b0_0_0_0_0_0_0_0_0_0_0);

      // Both starts together, then a stray StartDiv during MULT_RUN
      StartMult = 1'b1; StartDiv = 1'b1;
      tick();
      StartMult = 1'b0;
      chk("both_start", 11'b1_0_0_0_0_0_1_0_0_0_1);
      tick();
      StartDiv = 1'b0;
      MultDone = 1'b1;
      chk("start_in_run", 11'b0_0_0_0_0_0_1_0_0_0_1);
      tick();
      MultDone = 1'b0;
      chk("both_wb_mult", 11'b0_0_1_1_1_1_1_1_0_0_0);
      tick();
      chk("both_idle", 11'b0_0_1_1_0_0_0_0_0_0_0);

      // Asynchronous reset between edges during MULT_RUN
      StartMult = 1'b1;
      tick();
      StartMult = 1'b0;
      tick();
      #2;
      reset = 1'b1;
      #1;
      chk("rst_mid_op", 11'b0_0_0_0_0_0_0_0_0_0_0);
      reset = 1'b0;
      tick();
      MultDone = 1'b1;
      tick();
      MultDone = 1'b0;
      chk("rst_late_done", 11'b0_0_0_0_0_0_0_0_0_0_0);
      tick();
      chk("rst_still_idle", 11'b0_0_0_0_0_0_0_0_0_0_0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
